// File: rtl/carregador_pkg.sv
// Shared constants for the program loader: FSM state codes, byte width and frame limits.
package carregador_pkg;

  localparam int BYTE_W    = 8;
  localparam int MIN_WORDS = 1;

  localparam logic [BYTE_W-1:0] START_BYTE_DEF = 8'hA5;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GET_COUNT = 3'd1;
  localparam logic [2:0] S_GET_HI    = 3'd2;
  localparam logic [2:0] S_GET_LO    = 3'd3;
  localparam logic [2:0] S_WRITE     = 3'd4;
  localparam logic [2:0] S_GET_CSUM  = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;
  localparam logic [2:0] S_ERROR     = 3'd7;

  // A frame must carry at least one word and no more than the memory holds.
  function automatic logic count_ok(input logic [BYTE_W-1:0] n, input int addr_w);
    return (int'(n) >= MIN_WORDS) && (int'(n) <= (1 << addr_w));
  endfunction

endpackage

// File: rtl/carregador_programa_montador_palavra.sv
// montador_palavra: joins hi/lo bytes into one instruction word.
// The XOR checksum accumulator exists only when LOADER_CKSUM_EN is defined.
module montador_palavra
  import carregador_pkg::*;
(
  input  logic                  read_clock,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_hi_en,
  input  logic                  i_lo_en,
  input  logic [BYTE_W-1:0]     i_byte,
  output logic [2*BYTE_W-1:0]   o_word
`ifdef LOADER_CKSUM_EN
  ,
  output logic [BYTE_W-1:0]     o_csum
`endif
);

  logic [BYTE_W-1:0] r_hi;
  logic [BYTE_W-1:0] r_lo;

  always_ff @(posedge read_clock or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_clear) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (i_hi_en) r_hi <= i_byte;
      if (i_lo_en) r_lo <= i_byte;
    end
  end

  assign o_word = {r_hi, r_lo};

`ifdef LOADER_CKSUM_EN
  logic [BYTE_W-1:0] r_csum;

  always_ff @(posedge read_clock or negedge reset) begin
    if (!reset) begin
      r_csum <= '0;
    end else if (i_clear) begin
      r_csum <= '0;
    end else if (i_hi_en || i_lo_en) begin
      r_csum <= r_csum ^ i_byte;
    end
  end

  assign o_csum = r_csum;
`endif

endmodule

// File: rtl/carregador_programa.sv
// Program loader: turns a byte stream into sequential program-memory writes, halting the CPU meanwhile.
// Optional trailing XOR checksum byte is enabled with LOADER_CKSUM_EN.
module carregador_programa
  import carregador_pkg::*;
#(
  parameter int                DATA_WIDTH      = 16,
  parameter int                PROG_ADDR_WIDTH = 5,
  parameter logic [BYTE_W-1:0] START_BYTE      = START_BYTE_DEF
) (
  input  logic                       read_clock,
  input  logic                       reset,
  input  logic [BYTE_W-1:0]          byte_data,
  input  logic                       byte_valid,
  output logic                       byte_ready,
  output logic                       mem_we,
  output logic [PROG_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_data,
  output logic                       cpu_halt,
  output logic                       load_done,
  output logic                       load_error,
  output logic [PROG_ADDR_WIDTH:0]   words_loaded
);

  logic [2:0]                 r_state;
  logic [PROG_ADDR_WIDTH:0]   r_count;
  logic [PROG_ADDR_WIDTH:0]   r_words;
  logic [PROG_ADDR_WIDTH-1:0] r_mem_addr;
  logic                       r_mem_we;
  logic                       r_cpu_halt;
  logic                       r_load_done;
  logic                       r_load_error;

  logic                       w_accept;
  logic                       w_start;
  logic                       w_clear;
  logic                       w_hi_en;
  logic                       w_lo_en;
  logic [2*BYTE_W-1:0]        w_word;
  logic [PROG_ADDR_WIDTH:0]   w_words_inc;
`ifdef LOADER_CKSUM_EN
  logic [BYTE_W-1:0]          w_csum;
`endif

  assign byte_ready  = (r_state != S_WRITE) && (r_state != S_DONE);
  assign w_accept    = byte_valid && byte_ready;
  assign w_start     = w_accept && (byte_data == START_BYTE);
  assign w_clear     = w_start && ((r_state == S_IDLE) || (r_state == S_ERROR));
  assign w_hi_en     = w_accept && (r_state == S_GET_HI);
  assign w_lo_en     = w_accept && (r_state == S_GET_LO);
  assign w_words_inc = r_words + 1'b1;

  montador_palavra u_montador (
    .read_clock (read_clock),
    .reset      (reset),
    .i_clear    (w_clear),
    .i_hi_en    (w_hi_en),
    .i_lo_en    (w_lo_en),
    .i_byte     (byte_data),
    .o_word     (w_word)
`ifdef LOADER_CKSUM_EN
    ,
    .o_csum     (w_csum)
`endif
  );

  always_ff @(posedge read_clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_words      <= '0;
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_cpu_halt   <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_mem_we    <= 1'b0;
      r_load_done <= 1'b0;
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (w_clear) begin
            r_state      <= S_GET_COUNT;
            r_cpu_halt   <= 1'b1;
            r_words      <= '0;
            r_load_error <= 1'b0;
          end
        end
        S_GET_COUNT: begin
          if (w_accept) begin
            if (count_ok(byte_data, PROG_ADDR_WIDTH)) begin
              r_count <= byte_data[PROG_ADDR_WIDTH:0];
              r_state <= S_GET_HI;
            end else begin
              r_state      <= S_ERROR;
              r_load_error <= 1'b1;
            end
          end
        end
        S_GET_HI: begin
          if (w_accept) r_state <= S_GET_LO;
        end
        S_GET_LO: begin
          // Address is captured here so it is stable for the whole write cycle.
          if (w_accept) begin
            r_state    <= S_WRITE;
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_words[PROG_ADDR_WIDTH-1:0];
          end
        end
        S_WRITE: begin
          r_words <= w_words_inc;
          if (w_words_inc == r_count) begin
`ifdef LOADER_CKSUM_EN
            r_state <= S_GET_CSUM;
`else
            r_state     <= S_DONE;
            r_load_done <= 1'b1;
`endif
          end else begin
            r_state <= S_GET_HI;
          end
        end
`ifdef LOADER_CKSUM_EN
        S_GET_CSUM: begin
          if (w_accept) begin
            if (byte_data == w_csum) begin
              r_state     <= S_DONE;
              r_load_done <= 1'b1;
            end else begin
              r_state      <= S_ERROR;
              r_load_error <= 1'b1;
            end
          end
        end
`endif
        S_DONE: begin
          r_state    <= S_IDLE;
          r_cpu_halt <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_data     = w_word;
  assign cpu_halt     = r_cpu_halt;
  assign load_done    = r_load_done;
  assign load_error   = r_load_error;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_carregador_programa.sv
// Bench for carregador_programa: frames are scored against a per-frame expectation of writes and flags.
module tb_carregador_programa;

  logic        read_clock = 1'b0;
  logic        reset      = 1'b0;
  logic [7:0]  byte_data  = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [15:0] mem_data;
  logic        cpu_halt;
  logic        load_done;
  logic        load_error;
  logic [5:0]  words_loaded;

  carregador_programa dut (
    .read_clock   (read_clock),
    .reset        (reset),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .cpu_halt     (cpu_halt),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 read_clock = ~read_clock;

  int          n_tests  = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  int          gap_max  = 0;
  logic        prev_we  = 1'b0;
  logic [20:0] wr_q[$];
  logic [15:0] q_words[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: records every memory write and checks write-cycle properties.
  always @(negedge read_clock) begin
    if (reset && mem_we) begin
      wr_q.push_back({mem_addr, mem_data});
      chk("ready_low_in_write", 32'(byte_ready), 32'd0);
      chk("we_single_cycle", 32'(prev_we), 32'd0);
    end
    if (reset && load_done) done_cnt++;
    prev_we = mem_we;
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge read_clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    int g = int'($urandom_range(gap_max, 0));
    wait_cycles(g);
    byte_data  = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 100) begin
      @(posedge read_clock);
      #1;
      n++;
    end
    if (!byte_ready) chk("ready_timeout", 32'(byte_ready), 32'd1);
    @(posedge read_clock);
    #1;
    byte_valid = 1'b0;
  endtask

  // Expected outcome of a frame follows directly from N and checksum correctness.
  task automatic run_frame(input string tag, input int n_field, input logic [7:0] delta);
    logic [7:0] x = 8'h00;
    bit cnt_ok;
    bit ok;
    int done0;
    cnt_ok = (n_field >= 1) && (n_field <= 32);
    wr_q.delete();
    done0 = done_cnt;
    send_byte(8'hA5);
    send_byte(8'(n_field));
    ok = 1'b0;
    if (cnt_ok) begin
      for (int i = 0; i < n_field; i++) begin
        send_byte(q_words[i][15:8]);
        send_byte(q_words[i][7:0]);
        x = x ^ q_words[i][15:8] ^ q_words[i][7:0];
      end
`ifdef LOADER_CKSUM_EN
      send_byte(x ^ delta);
      ok = (delta == 8'h00);
`else
      ok = 1'b1;
`endif
    end
    wait_cycles(4);
    chk({tag, "_nwrites"}, 32'(wr_q.size()), cnt_ok ? 32'(n_field) : 32'd0);
    for (int i = 0; i < wr_q.size() && i < n_field; i++)
      chk({tag, "_write"}, 32'(wr_q[i]), 32'({5'(i), q_words[i]}));
    chk({tag, "_done"}, 32'(done_cnt - done0), ok ? 32'd1 : 32'd0);
    chk({tag, "_error"}, 32'(load_error), ok ? 32'd0 : 32'd1);
    chk({tag, "_halt"}, 32'(cpu_halt), ok ? 32'd0 : 32'd1);
    chk({tag, "_words"}, 32'(words_loaded), cnt_ok ? 32'(n_field) : 32'd0);
    chk({tag, "_ready"}, 32'(byte_ready), 32'd1);
    $display("[TB] frame %s n=%0d delta=%0h writes=%0d done=%0d err=%0b",
             tag, n_field, delta, wr_q.size(), done_cnt - done0, load_error);
  endtask

  task automatic fill_random(input int n);
    q_words.delete();
    for (int i = 0; i < n; i++) q_words.push_back(16'($urandom));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_ready", 32'(byte_ready), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_halt", 32'(cpu_halt), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_error", 32'(load_error), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_addr_data", 32'({mem_addr, mem_data}), 32'd0);
    @(posedge read_clock);
    #1;
    reset = 1'b1;
    wait_cycles(2);

    // Reset while the second word's lo byte is awaited.
    q_words = '{16'h1234, 16'h5678};
    wr_q.delete();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    reset = 1'b0;
    #1;
    chk("midrst_halt", 32'(cpu_halt), 32'd0);
    chk("midrst_we", 32'(mem_we), 32'd0);
    chk("midrst_ready", 32'(byte_ready), 32'd1);
    chk("midrst_words", 32'(words_loaded), 32'd0);
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(5);
    chk("midrst_writes", 32'(wr_q.size()), 32'd1);
    $display("[TB] reset mid-frame, writes before reset=%0d", wr_q.size());
    run_frame("resend", 2, 8'h00);

    q_words = '{16'h1234, 16'hABCD};
    run_frame("good2", 2, 8'h00);
    run_frame("badcsum", 2, 8'h01);
    run_frame("recover", 2, 8'h00);

    run_frame("n0", 0, 8'h00);
    run_frame("n33", 33, 8'h00);
    fill_random(32);
    run_frame("n32", 32, 8'h00);

    wr_q.delete();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    wait_cycles(3);
    chk("noise_halt", 32'(cpu_halt), 32'd0);
    chk("noise_writes", 32'(wr_q.size()), 32'd0);
    $display("[TB] noise bytes 00 FF 5A sent");
    q_words = '{16'hA5A5};
    run_frame("startdata", 1, 8'h00);
    q_words = '{16'hBEEF};
    run_frame("beef", 1, 8'h00);

    fill_random(8);
    gap_max = 0;
    run_frame("img_nogap", 8, 8'h00);
    gap_max = 4;
    run_frame("img_gap", 8, 8'h00);

    for (int r = 0; r < 6; r++) begin
      int n = int'($urandom_range(32, 1));
      logic [7:0] d = ($urandom_range(3, 0) == 0) ? 8'(8'h01 << $urandom_range(7, 0)) : 8'h00;
      gap_max = (r % 2 == 1) ? 3 : 0;
      fill_random(n);
      run_frame("rand", n, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/carregador_programa.md
Name: carregador_programa

Overview:
- Program loader sitting directly upstream of memoriaDePrograma; drives the currently unused write port (dataMemProg, write_addr, we_memProg).
- Receives a byte stream (valid/ready) from a serial front end, assembles 16-bit instruction words and writes them sequentially from address 0.
- Holds the processor via cpu_halt while loading; on success pulses load_done so the top level can restart the PC at 0.

Parameters:
- DATA_WIDTH, 16, instruction width; fixed at two bytes, MSB first.
- PROG_ADDR_WIDTH, 5, program memory address width (32 words).
- START_BYTE, 8'hA5, byte that opens a load frame.

Ports:
- read_clock  in  1  system clock (FPGA clock); all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- byte_data  in  8  incoming byte.
- byte_valid  in  1  byte_data valid this cycle.
- byte_ready  out  1  loader accepts byte; transfer when byte_valid & byte_ready.
- mem_we  out  1  program memory write enable (to we_memProg), one-cycle pulse.
- mem_addr  out  PROG_ADDR_WIDTH  write address (to write_addr).
- mem_data  out  DATA_WIDTH  write data (to dataMemProg).
- cpu_halt  out  1  high while a frame is in progress or after an error.
- load_done  out  1  one-cycle pulse after a successful frame.
- load_error  out  1  sticky error flag.
- words_loaded  out  PROG_ADDR_WIDTH+1  words written in current/last frame.

Behaviour:
- Reset values: all outputs 0, except byte_ready = 1. State IDLE; word counter and checksum 0.
- Frame format: START_BYTE, N (word count), N×(hi byte, lo byte), checksum byte (XOR of all hi/lo bytes; only with the optional feature).
- States: IDLE, GET_COUNT, GET_HI, GET_LO, WRITE, GET_CSUM, DONE, ERROR.
- IDLE: byte_ready=1. A byte ≠ START_BYTE is discarded. START_BYTE -> GET_COUNT; the next cycle sets cpu_halt=1, clears words_loaded, load_error and checksum.
- GET_COUNT: N=0 or N>2^PROG_ADDR_WIDTH -> ERROR; otherwise latch N and go to GET_HI.
- GET_HI: latch mem_data[15:8] -> GET_LO. GET_LO: latch mem_data[7:0] -> WRITE. Each accepted data byte is XORed into the checksum.
- WRITE: byte_ready=0; mem_we=1 for exactly this cycle; mem_addr = words_loaded[PROG_ADDR_WIDTH-1:0].
  - Next cycle: words_loaded increments.
  - If words_loaded+1 == N, go to GET_CSUM (feature on) or DONE; else GET_HI.
- mem_addr and mem_data are registered and stable during the mem_we cycle.
- GET_CSUM: match -> DONE; mismatch -> ERROR.
- DONE: one cycle; load_done=1, cpu_halt falls to 0 on exit, byte_ready=0. -> IDLE.
- ERROR: load_error=1, cpu_halt held at 1, byte_ready=1. Bytes other than START_BYTE are discarded; START_BYTE restarts at GET_COUNT (clears load_error).
- START_BYTE inside a frame is plain data.
- No timeout; the loader waits indefinitely while byte_valid is low.
- Reset mid-frame: immediate return to IDLE, cpu_halt=0, mem_we=0. Partially written memory is not restored.
- Latency: the lo byte is accepted in cycle t; mem_we is high in cycle t+1. Minimum 3 cycles per word.

Optional Feature:
- Macro: LOADER_CKSUM_EN.
  - Defined: GET_CSUM state and checksum register exist; a mismatch gives ERROR.
  - Undefined: frame ends after the last word; WRITE goes directly to DONE; no checksum logic.

Decomposition:
- Package carregador_pkg: state encoding constants (3-bit), START_BYTE default, byte width 8, frame length limits.
- One natural sub-module, montador_palavra: assembles hi/lo bytes and accumulates the XOR checksum; clear/hi_en/lo_en inputs, word and checksum outputs.
- The FSM and write addressing stay in carregador_programa.

Test Plan:
- Reset mid-GET_LO (frame A5,02,12,34,56) -> reset asserted low: state IDLE, cpu_halt=0, no further mem_we. Same frame resent after release loads correctly.
- A5,02,12,34,AB,CD,(cksum 12^34^AB^CD=40) -> two mem_we pulses (addr0=1234, addr1=ABCD), load_done pulse, cpu_halt low, words_loaded=2.
- Same frame with checksum 41 -> load_error=1, cpu_halt stays 1. A following valid frame clears the error and completes.
- Counts and ready: A5,00 -> ERROR. A5,21 (33 > 32) -> ERROR. A5,20 + 32 words -> last write at addr 31, words_loaded=32. byte_ready is 0 in every WRITE cycle.
- Noise and start-byte handling: bytes 00,FF,5A in IDLE -> ignored, cpu_halt stays 0. Frame A5,01,A5,A5,cksum 00 -> A5A5 written at addr0 (start byte as data).
- Feature off: A5,01,BE,EF -> DONE right after the write, with no checksum byte consumed.
- Gapped byte_valid (random idle cycles) -> identical memory image.
